// File: rtl/snake_body_if.sv
// Bundle between the game FSM / body RAM side (master) and the body sequencer (slave).
// Carries move requests, RAM port signals and status.
interface snake_body_if;
    logic       move;
    logic [1:0] dir;
    logic       grow;
    logic [5:0] ram_q;
    logic [5:0] ram_head;
    logic       ram_we;
    logic [5:0] ram_addr;
    logic [5:0] ram_data;
    logic [6:0] length;
    logic       busy;
    logic       done;
    logic       collision;

    modport master (
        output move, dir, grow, ram_q, ram_head,
        input  ram_we, ram_addr, ram_data, length, busy, done, collision
    );

    modport slave (
        input  move, dir, grow, ram_q, ram_head,
        output ram_we, ram_addr, ram_data, length, busy, done, collision
    );
endinterface

// File: rtl/snake_body_ctrl.sv
// Snake-body RAM sequencer: shifts the body one slot toward the tail, writes the new
// head into slot 0, optionally grows, and flags self-collision against surviving segments.
module snake_body_ctrl #(
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 2
) (
    input  logic         clk,
    input  logic         restart,
    snake_body_if.slave  io_bus
);

    localparam logic [6:0] LEN_MAX  = 7'(MAX_LEN);
    localparam logic [6:0] LEN_INIT = 7'(INIT_LEN);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        RD,
        WR,
        HEAD,
        DONE
    } state_t;

    state_t     r_state;
    state_t     w_nextState;

    logic [1:0] r_lastDir;
    logic [1:0] r_effDir;
    logic [1:0] w_effDir;
    logic       r_grow;
    logic [5:0] r_idx;
    logic [5:0] r_newHead;
    logic [5:0] w_stepHead;
    logic [6:0] r_length;
    logic       r_hit;
    logic       r_collision;
    logic       w_accept;
    logic       w_ramWe;
    logic [5:0] w_ramAddr;
    logic [5:0] w_ramData;
    logic [2:0] w_x;
    logic [2:0] w_y;

    // A request for the opposite direction would fold the head back onto the neck.
    assign w_effDir = ((io_bus.dir ^ 2'b10) == r_lastDir) ? r_lastDir : io_bus.dir;
    assign w_accept = (r_state == IDLE) && io_bus.move && !r_collision;

    always_comb begin
        w_x = io_bus.ram_head[2:0];
        w_y = io_bus.ram_head[5:3];
        case (r_effDir)
            2'b00:   w_x = w_x + 3'd1;
            2'b01:   w_y = w_y + 3'd1;
            2'b10:   w_x = w_x - 3'd1;
            default: w_y = w_y - 3'd1;
        endcase
        w_stepHead = {w_y, w_x};
    end

    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_ramWe     = 1'b0;
        w_ramAddr   = 6'd0;
        w_ramData   = 6'd0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = CALC;
                end
            end
            CALC: begin
                w_nextState = RD;
            end
            RD: begin
                w_ramAddr   = r_idx - 6'd1;
                w_nextState = WR;
            end
            WR: begin
                w_ramAddr   = r_idx;
                w_ramData   = io_bus.ram_q;
                w_ramWe     = 1'b1;
                w_nextState = (r_idx == 6'd1) ? HEAD : RD;
            end
            HEAD: begin
                w_ramAddr   = 6'd0;
                w_ramData   = r_newHead;
                w_ramWe     = 1'b1;
                w_nextState = DONE;
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // The low six bits of length minus one wrap 64 to 63, which is the full-body tail index.
    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            r_lastDir   <= 2'b00;
            r_effDir    <= 2'b00;
            r_grow      <= 1'b0;
            r_idx       <= 6'd0;
            r_newHead   <= 6'd0;
            r_length    <= LEN_INIT;
            r_hit       <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_grow   <= io_bus.grow;
                        r_effDir <= w_effDir;
                    end
                end
                CALC: begin
                    r_newHead <= w_stepHead;
                    r_hit     <= 1'b0;
                    if (r_grow && (r_length < LEN_MAX)) begin
                        r_idx <= r_length[5:0];
                    end else begin
                        r_idx  <= r_length[5:0] - 6'd1;
                        r_grow <= 1'b0;
                    end
                end
                WR: begin
                    if (io_bus.ram_q == r_newHead) begin
                        r_hit <= 1'b1;
                    end
                    if (r_idx != 6'd1) begin
                        r_idx <= r_idx - 6'd1;
                    end
                end
                DONE: begin
                    r_length    <= r_length + {6'd0, r_grow};
                    r_collision <= r_collision | r_hit;
                    r_lastDir   <= r_effDir;
                end
                default: begin
                end
            endcase
        end
    end

    assign io_bus.ram_we    = w_ramWe;
    assign io_bus.ram_addr  = w_ramAddr;
    assign io_bus.ram_data  = w_ramData;
    assign io_bus.length    = r_length;
    assign io_bus.busy      = (r_state != IDLE);
    assign io_bus.done      = (r_state == DONE);
    assign io_bus.collision = r_collision;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Directed bench for snake_body_ctrl with a behavioural 64x6 body RAM
// (sync write, registered read address, slots 0/1 restored on restart).
module tb_snake_body_ctrl;

    logic clk;
    logic restart;
    int   compared;
    int   mismatched;

    snake_body_if bus ();

    snake_body_ctrl #(
        .MAX_LEN  (64),
        .INIT_LEN (2)
    ) dut (
        .clk     (clk),
        .restart (restart),
        .io_bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] mem [64];
    logic [5:0] ramAddrReg;

    always @(posedge clk or posedge restart) begin
        if (restart) begin
            mem[0]     <= 6'b001011;
            mem[1]     <= 6'b000101;
            ramAddrReg <= 6'd0;
        end else begin
            ramAddrReg <= bus.ram_addr;
            if (bus.ram_we) begin
                mem[bus.ram_addr] <= bus.ram_data;
            end
        end
    end

    assign bus.ram_q    = mem[ramAddrReg];
    assign bus.ram_head = mem[0];

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic resetDut();
        bus.move = 1'b0;
        bus.grow = 1'b0;
        bus.dir  = 2'b00;
        restart  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
    endtask

    // Pulse one move and return the cycle index (CALC = 1) at which done was seen.
    task automatic applyStimulus(input logic [1:0] d, input logic g, output int latency);
        @(negedge clk);
        bus.move = 1'b1;
        bus.dir  = d;
        bus.grow = g;
        @(negedge clk);
        bus.move = 1'b0;
        bus.grow = 1'b0;
        latency  = 1;
        while (!bus.done && latency < 300) begin
            @(negedge clk);
            latency++;
        end
        @(negedge clk);
    endtask

    task automatic probeIgnored(input logic [1:0] d, output int activity);
        @(negedge clk);
        bus.move = 1'b1;
        bus.dir  = d;
        @(negedge clk);
        bus.move = 1'b0;
        activity = 0;
        repeat (10) begin
            if (bus.ram_we || bus.busy || bus.done) activity++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [1:0] t3Dir  [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b01};
    logic [5:0] t3Head [8] = '{6'b001100, 6'b001101, 6'b001110, 6'b001111,
                               6'b001000, 6'b000000, 6'b111000, 6'b110000};

    logic [1:0] t5Dir  [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
    logic       t5Grow [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [5:0] t5Head [6] = '{6'b001100, 6'b001101, 6'b001110, 6'b010110, 6'b010101, 6'b001101};
    int         t5Lat  [6] = '{7, 9, 11, 11, 11, 11};
    int         t5Len  [6] = '{3, 4, 5, 5, 5, 5};
    int         t5Coll [6] = '{0, 0, 0, 0, 0, 1};

    initial begin
        int         lat;
        int         act;
        int         sumLat;
        int         expSumLat;
        int         modelLen;
        int         dones;
        logic [1:0] path [$];

        compared   = 0;
        mismatched = 0;
        restart    = 1'b1;
        bus.move   = 1'b0;
        bus.dir    = 2'b00;
        bus.grow   = 1'b0;

        resetDut();
        checkOutput("rst_length", bus.length, 2);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_we", bus.ram_we, 0);
        checkOutput("rst_addr", bus.ram_addr, 0);
        checkOutput("rst_data", bus.ram_data, 0);
        checkOutput("rst_coll", bus.collision, 0);

        applyStimulus(2'b00, 1'b0, lat);
        checkOutput("t1_latency", lat, 5);
        checkOutput("t1_ram0", mem[0], 6'b001100);
        checkOutput("t1_ram1", mem[1], 6'b001011);
        checkOutput("t1_length", bus.length, 2);
        checkOutput("t1_coll", bus.collision, 0);

        resetDut();
        applyStimulus(2'b00, 1'b1, lat);
        checkOutput("t2_latency", lat, 7);
        checkOutput("t2_ram0", mem[0], 6'b001100);
        checkOutput("t2_ram1", mem[1], 6'b001011);
        checkOutput("t2_ram2", mem[2], 6'b000101);
        checkOutput("t2_length", bus.length, 3);

        resetDut();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(t3Dir[i], 1'b0, lat);
            checkOutput($sformatf("t3_head%0d", i), mem[0], t3Head[i]);
            checkOutput($sformatf("t3_lat%0d", i), lat, 5);
        end

        resetDut();
        applyStimulus(2'b10, 1'b0, lat);
        checkOutput("t4_reverse_head", mem[0], 6'b001100);
        checkOutput("t4_reverse_ram1", mem[1], 6'b001011);

        resetDut();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(t5Dir[i], t5Grow[i], lat);
            checkOutput($sformatf("t5_head%0d", i), mem[0], t5Head[i]);
            checkOutput($sformatf("t5_lat%0d", i), lat, t5Lat[i]);
            checkOutput($sformatf("t5_len%0d", i), bus.length, t5Len[i]);
            checkOutput($sformatf("t5_coll%0d", i), bus.collision, t5Coll[i]);
        end
        probeIgnored(2'b01, act);
        checkOutput("t5_ignored_activity", act, 0);
        checkOutput("t5_ignored_head", mem[0], 6'b001101);
        checkOutput("t5_ignored_len", bus.length, 5);

        // Serpentine over the torus that fills every cell except the original tail (5,0).
        resetDut();
        checkOutput("t6_coll_cleared", bus.collision, 0);
        for (int i = 0; i < 7; i++) path.push_back(2'b00);
        for (int r = 0; r < 6; r++) begin
            path.push_back(2'b01);
            for (int i = 0; i < 7; i++) path.push_back(2'b00);
        end
        path.push_back(2'b01);
        for (int i = 0; i < 6; i++) path.push_back(2'b10);
        checkOutput("t6_path_len", path.size(), 62);

        modelLen  = 2;
        sumLat    = 0;
        expSumLat = 0;
        foreach (path[i]) begin
            applyStimulus(path[i], 1'b1, lat);
            sumLat    += lat;
            expSumLat += 2 * modelLen + 3;
            modelLen++;
        end
        checkOutput("t6_grow_latency_sum", sumLat, expSumLat);
        checkOutput("t6_len64", bus.length, 64);
        checkOutput("t6_coll_full", bus.collision, 0);
        checkOutput("t6_head_full", mem[0], 6'b000110);
        checkOutput("t6_tail_full", mem[63], 6'b000101);

        applyStimulus(2'b10, 1'b1, lat);
        checkOutput("t6_cap_latency", lat, 129);
        checkOutput("t6_cap_len", bus.length, 64);
        checkOutput("t6_cap_head", mem[0], 6'b000101);
        checkOutput("t6_cap_tail", mem[63], 6'b001011);
        checkOutput("t6_cap_coll", bus.collision, 0);

        @(negedge clk);
        bus.move = 1'b1;
        bus.dir  = 2'b10;
        @(negedge clk);
        bus.move = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t6_in_wr_we", bus.ram_we, 1);
        restart = 1'b1;
        #1;
        checkOutput("t6_abort_length", bus.length, 2);
        checkOutput("t6_abort_busy", bus.busy, 0);
        checkOutput("t6_abort_we", bus.ram_we, 0);
        checkOutput("t6_abort_addr", bus.ram_addr, 0);
        checkOutput("t6_abort_data", bus.ram_data, 0);
        checkOutput("t6_abort_done", bus.done, 0);
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);

        @(negedge clk);
        bus.move = 1'b1;
        bus.dir  = 2'b00;
        @(negedge clk);
        bus.move = 1'b0;
        checkOutput("t6_busy_high", bus.busy, 1);
        @(negedge clk);
        bus.move = 1'b1;
        bus.dir  = 2'b01;
        @(negedge clk);
        bus.move = 1'b0;
        dones = 0;
        repeat (20) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        checkOutput("t6_busy_move_dones", dones, 1);
        checkOutput("t6_busy_move_head", mem[0], 6'b001100);
        checkOutput("t6_busy_move_idle", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
